// File: rtl/cmp_pkg.sv
// Shared encodings for the sequential compare unit: compare modes and FSM states.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package cmp_pkg;

  // Comparison selected by the requester, sampled together with the operands.
  typedef enum logic [1:0] {
    CMP_EQ  = 2'b00,
    CMP_NE  = 2'b01,
    CMP_LTS = 2'b10,
    CMP_LTU = 2'b11
  } cmp_mode_t;

  // Control states of the chunk-serial compare.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } cmp_state_t;

  // Map the raw eq/lt flags onto the outcome the requested mode asks for.
  function automatic logic sel_result(cmp_mode_t m, logic eq, logic lt);
    case (m)
      CMP_EQ:  return eq;
      CMP_NE:  return !eq;
      default: return lt;
    endcase
  endfunction

endpackage

// File: rtl/cmp_seq_if.sv
// Request/response bundle between a requester (branch/SLT path) and cmp_seq.
// Latency: n/a (wiring only).
// Backpressure: start is only honoured while busy is low and no done is pending.
interface cmp_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic             result;
  logic             eq;
  logic             lt;

  modport master (
    output start, a, b, mode,
    input  busy, done, result, eq, lt
  );

  modport slave (
    input  start, a, b, mode,
    output busy, done, result, eq, lt
  );
endinterface

// File: rtl/cmp_chunk.sv
// Combinational compare of one CHUNK-bit slice; signed_top biases the MSB for a signed top chunk.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             signed_top,
  output logic             ceq,
  output logic             clt
);

  logic [CHUNK-1:0] xs;
  logic [CHUNK-1:0] ys;

  // Flipping both sign bits turns a two's-complement order into an unsigned one.
  always_comb begin
    xs = x;
    ys = y;
    if (signed_top) begin
      xs[CHUNK-1] = ~x[CHUNK-1];
      ys[CHUNK-1] = ~y[CHUNK-1];
    end
    ceq = (x == y);
    clt = (xs < ys);
  end

endmodule

// File: rtl/cmp_seq.sv
// Multi-cycle EQ/NE/LTS/LTU compare, CHUNK bits per cycle from the top, early exit on first difference.
// Latency: 2 cycles (top chunk differs) up to NCHUNK+1 cycles (equal operands) from accept to done.
// Backpressure: start ignored while busy or in the done cycle; no queuing, requester must retry.
module cmp_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic       clock,
  input logic       reset,
  cmp_seq_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  cmp_state_t       state_q, state_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  cmp_mode_t        mode_q, mode_nxt;
  logic [IDXW-1:0]  idx_q, idx_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             result_q, result_nxt;
  logic             eq_q, eq_nxt;
  logic             lt_q, lt_nxt;

  // Latched operands viewed as chunk arrays so the index selects a slice directly.
  logic [NCHUNK-1:0][CHUNK-1:0] a_chunks;
  logic [NCHUNK-1:0][CHUNK-1:0] b_chunks;
  logic                         signed_top;
  logic                         ceq;
  logic                         clt;

  assign a_chunks   = a_q;
  assign b_chunks   = b_q;
  assign signed_top = (mode_q == CMP_LTS) && (idx_q == IDX_TOP);

  cmp_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .x          (a_chunks[idx_q]),
    .y          (b_chunks[idx_q]),
    .signed_top (signed_top),
    .ceq        (ceq),
    .clt        (clt)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  // Next state, operand capture, index walk and result computation.
  always_comb begin
    state_nxt  = state_q;
    a_nxt      = a_q;
    b_nxt      = b_q;
    mode_nxt   = mode_q;
    idx_nxt    = idx_q;
    result_nxt = result_q;
    eq_nxt     = eq_q;
    lt_nxt     = lt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_nxt     = bus.a;
          b_nxt     = bus.b;
          mode_nxt  = cmp_mode_t'(bus.mode);
          idx_nxt   = IDX_TOP;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!ceq) begin
          // First differing chunk from the top decides the order.
          eq_nxt     = 1'b0;
          lt_nxt     = clt;
          result_nxt = sel_result(mode_q, 1'b0, clt);
          state_nxt  = S_DONE;
        end else if (idx_q == '0) begin
          eq_nxt     = 1'b1;
          lt_nxt     = 1'b0;
          result_nxt = sel_result(mode_q, 1'b1, 1'b0);
          state_nxt  = S_DONE;
        end else begin
          idx_nxt = idx_q - IDXW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Status flags follow the state being entered so they are registered, not decoded.
    busy_nxt = (state_nxt == S_RUN);
    done_nxt = (state_nxt == S_DONE);
  end

  // Datapath and output registers; results hold until the next compare finishes.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= CMP_EQ;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      a_q      <= a_nxt;
      b_q      <= b_nxt;
      mode_q   <= mode_nxt;
      idx_q    <= idx_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      result_q <= result_nxt;
      eq_q     <= eq_nxt;
      lt_q     <= lt_nxt;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.eq     = eq_q;
  assign bus.lt     = lt_q;

endmodule

// File: tb/tb_cmp_seq.sv
// Self-checking bench for cmp_seq: directed plan cases, randomized compares, handshake and reset.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_cmp_seq;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cmp_seq_if #(.WIDTH(WIDTH)) bus ();

  cmp_seq #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Reference: whole-word comparison plus chunks-examined count from the highest differing bit.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                                    output logic r, output logic e, output logic l, output int k);
    logic [31:0] diff;
    int msb;
    e    = (a == b);
    l    = (m == 2'b10) ? ($signed(a) < $signed(b)) : (a < b);
    r    = (m == 2'b00) ? e : (m == 2'b01) ? !e : l;
    diff = a ^ b;
    msb  = -1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (diff[i] && msb < 0) msb = i;
    end
    k = (msb < 0) ? NCH : NCH - (msb / CHUNK);
  endfunction

  // Issue one request and follow it to done. acc = edges until busy rose (-1 if never),
  // cyc = cycle index after acceptance where done was seen (-1 if never), busy_bad = busy errors.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                       input bit scramble, input bit hold_start,
                       output int acc, output int cyc, output int busy_bad);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.mode  = m;
    acc       = 0;
    cyc       = -1;
    busy_bad  = 0;
    do begin
      @(posedge clk); #1;
      acc++;
    end while (bus.busy !== 1'b1 && acc < 4);
    if (!hold_start) bus.start = 1'b0;
    if (bus.busy !== 1'b1) begin
      acc = -1;
      return;
    end
    for (int c = 1; c <= NCH + 4; c++) begin
      if (bus.done === 1'b1) begin
        cyc = c;
        break;
      end
      if (bus.busy !== 1'b1) busy_bad++;
      if (scramble) begin
        bus.a    = $urandom;
        bus.b    = $urandom;
        bus.mode = 2'($urandom);
      end
      @(posedge clk); #1;
    end
    if (cyc > 0 && bus.busy !== 1'b0) busy_bad++;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.mode  = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy   !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done   !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.result !== 1'b0) begin bad++; $display("FAIL reset_result got=%b want=0", bus.result); end
    total++; if (bus.eq     !== 1'b0) begin bad++; $display("FAIL reset_eq got=%b want=0", bus.eq); end
    total++; if (bus.lt     !== 1'b0) begin bad++; $display("FAIL reset_lt got=%b want=0", bus.lt); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [31:0] ta [5] = '{32'h12345678, 32'h80000000, 32'h80000000, 32'h000000FF, 32'h000000FF};
    logic [31:0] tb [5] = '{32'h12345678, 32'h00000001, 32'h00000001, 32'h00000100, 32'h00000100};
    logic [1:0]  tm [5] = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b01};
    int          tc [5] = '{5, 2, 2, 4, 4};
    logic        tr [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        te [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        tl [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int acc, cyc, bb;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      do_op(ta[i], tb[i], tm[i], 1'b0, 1'b0, acc, cyc, bb);
      total++; if (cyc !== tc[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, cyc, tc[i]); end
      total++; if (bus.result !== tr[i]) begin bad++; $display("FAIL dir%0d_result got=%b want=%b", i, bus.result, tr[i]); end
      total++; if (bus.eq !== te[i]) begin bad++; $display("FAIL dir%0d_eq got=%b want=%b", i, bus.eq, te[i]); end
      total++; if (bus.lt !== tl[i]) begin bad++; $display("FAIL dir%0d_lt got=%b want=%b", i, bus.lt, tl[i]); end
      total++; if (bb !== 0) begin bad++; $display("FAIL dir%0d_busy errors=%0d want=0", i, bb); end
      @(posedge clk); #1;
      total++; if (bus.done !== 1'b0 || bus.result !== tr[i]) begin
        bad++; $display("FAIL dir%0d_hold done=%b result=%b want done=0 result=%b", i, bus.done, bus.result, tr[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [1:0]  m;
    logic        r, e, l;
    int          k, acc, cyc, bb, p;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      m = 2'($urandom);
      p = $urandom_range(0, WIDTH - 1);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = $urandom;
        default: b = a ^ (32'h1 << p) ^ ($urandom & ((32'h1 << p) - 32'h1));
      endcase
      ref_model(a, b, m, r, e, l, k);
      @(posedge clk); #1;
      do_op(a, b, m, 1'b1, 1'b0, acc, cyc, bb);
      total++; if (cyc !== k + 1) begin bad++; $display("FAIL rnd%0d_latency a=%h b=%h got=%0d want=%0d", i, a, b, cyc, k + 1); end
      total++; if (bus.result !== r || bus.eq !== e || bus.lt !== l) begin
        bad++; $display("FAIL rnd%0d_flags a=%h b=%h m=%0d got r/e/l=%b%b%b want=%b%b%b",
                        i, a, b, m, bus.result, bus.eq, bus.lt, r, e, l);
      end
      total++; if (bb !== 0) begin bad++; $display("FAIL rnd%0d_busy errors=%0d want=0", i, bb); end
    end
  endtask

  task automatic test_busy_ignore;
    int acc, cyc, bb;
    @(posedge clk); #1;
    do_op(32'h12345678, 32'h12345678, 2'b00, 1'b1, 1'b1, acc, cyc, bb);
    total++; if (cyc !== 5 || bus.result !== 1'b1) begin
      bad++; $display("FAIL hold_first latency=%0d result=%b want 5/1", cyc, bus.result);
    end
    bus.a    = 32'h00000001;
    bus.b    = 32'h00000002;
    bus.mode = 2'b11;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL hold_after_done busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
    do_op(32'h00000001, 32'h00000002, 2'b11, 1'b0, 1'b0, acc, cyc, bb);
    total++; if (acc !== 1 || cyc !== 5 || bus.result !== 1'b1) begin
      bad++; $display("FAIL hold_second acc=%0d latency=%0d result=%b want 1/5/1", acc, cyc, bus.result);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    logic        r, e, l;
    int          k, acc, cyc, bb;
    @(posedge clk); #1;
    do_op(32'hDEADBEEF, 32'hDEADBE00, 2'b11, 1'b0, 1'b0, acc, cyc, bb);
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? a : $urandom;
      ref_model(a, b, 2'(i), r, e, l, k);
      do_op(a, b, 2'(i), 1'b0, 1'b0, acc, cyc, bb);
      total++; if (acc !== 2) begin bad++; $display("FAIL b2b%0d_accept edges=%0d want=2", i, acc); end
      total++; if (cyc !== k + 1 || bus.result !== r) begin
        bad++; $display("FAIL b2b%0d_op latency=%0d result=%b want %0d/%b", i, cyc, bus.result, k + 1, r);
      end
    end
  endtask

  task automatic test_reset_midflight;
    int acc, cyc, bb, pulses;
    @(posedge clk); #1;
    do_op(32'h5, 32'h5, 2'b00, 1'b0, 1'b0, acc, cyc, bb);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 32'h12345678;
    bus.b     = 32'h12345678;
    bus.mode  = 2'b00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctrl busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
    total++; if (bus.result !== 1'b0 || bus.eq !== 1'b0 || bus.lt !== 1'b0) begin
      bad++; $display("FAIL rstmid_flags r/e/l=%b%b%b want 000", bus.result, bus.eq, bus.lt);
    end
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rstmid_no_done pulses=%0d want=0", pulses); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
